fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined RV32 core.
- Replaces the single-register PC/fetch stage with a prefetch engine that has:
  - a decoupled valid/ready request channel to instruction memory;
  - an in-order response channel;
  - a DEPTH-entry fetch queue feeding decode.
- Supports stall from decode, branch/jump redirect, trap redirect, in-flight kill, and misaligned/bus-error faults.

---
 rtl/riscv.sv | 30 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv.sv
// Shared RV32 core definitions: address/instruction types, boot and trap vectors,
// and the fetch-queue entry, cause and state types.
package riscv;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [31:0]     inst_t;

  localparam word_t INST_ADDR = 32'h0000_0000;
  localparam word_t TRAP_ADDR = 32'h0000_0080;

  typedef enum logic [1:0] {
    FETCH_MISALIGNED = 2'd0,
    FETCH_BUS_ERROR  = 2'd1
  } fetch_cause_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

  typedef struct packed {
    word_t        pc;
    inst_t        ir;
    logic         fault;
    fetch_cause_t cause;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush; the head is read straight from storage
// registers, so rd_data has no combinational path from push/wr_data.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      do_push  = 1'b0;
      do_pop   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction-fetch front end: credit-limited request issue, in-order
// responses tagged with their request PC, and a fetch queue feeding decode.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = riscv::INST_ADDR,
  parameter logic [XLEN-1:0] TRAP_ADDR  = riscv::TRAP_ADDR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_error,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_ir,
  output logic            id_fault,
  output logic [1:0]      id_cause
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + 35;

  riscv::fetch_state_t state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [CW-1:0]       kill_cnt_q, kill_cnt_d;
  logic                mis_pend_q, mis_pend_d;

  logic                flush, req_hs, q_push, q_empty, tag_empty;
  logic [EW-1:0]       q_wr, q_rd;
  logic [CW-1:0]       q_cnt, tag_cnt;
  logic [XLEN-1:0]     tag_pc;
  logic [CW:0]         credit;

  assign flush          = redirect_valid | trap;
  assign credit         = {1'b0, out_cnt_q} + {1'b0, q_cnt};
  assign imem_req_valid = ~reset & (state_q == riscv::FETCH_RUN) & ~mis_pend_q
                        & (credit < (CW+1)'(DEPTH)) & ~flush;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    kill_cnt_d = kill_cnt_q;
    mis_pend_d = mis_pend_q;
    q_push     = 1'b0;
    q_wr       = '0;

    if (req_hs) begin
      out_cnt_d = out_cnt_d + 1'b1;
      pc_d      = pc_q + XLEN'(4);
    end
    if (imem_rsp_valid) out_cnt_d = out_cnt_d - 1'b1;

    if (flush) begin
      // A response landing in the redirect cycle is dropped here, not counted as a kill.
      kill_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
      pc_d       = trap ? TRAP_ADDR : redirect_addr;
      state_d    = riscv::FETCH_RUN;
      mis_pend_d = ~trap & (redirect_addr[1:0] != 2'b00);
    end else begin
      if (imem_rsp_valid) begin
        if (kill_cnt_q != '0) begin
          kill_cnt_d = kill_cnt_q - 1'b1;
        end else begin
          q_push = 1'b1;
          q_wr   = {tag_pc, imem_rsp_data, imem_rsp_error, riscv::FETCH_BUS_ERROR};
          if (imem_rsp_error) state_d = riscv::FETCH_HALT;
        end
      end
      // Misaligned target waits for the old path to drain so the fault stays in order.
      if (mis_pend_q && kill_cnt_q == '0) begin
        q_push     = 1'b1;
        q_wr       = {pc_q, 32'h0, 1'b1, riscv::FETCH_MISALIGNED};
        mis_pend_d = 1'b0;
        state_d    = riscv::FETCH_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= riscv::FETCH_RUN;
      pc_q       <= RESET_ADDR;
      out_cnt_q  <= '0;
      kill_cnt_q <= '0;
      mis_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      mis_pend_q <= mis_pend_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (1'b0),
    .push    (req_hs),
    .wr_data (pc_q),
    .pop     (imem_rsp_valid),
    .rd_data (tag_pc),
    .empty   (tag_empty),
    .count   (tag_cnt)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_q (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (q_push),
    .wr_data (q_wr),
    .pop     (id_valid & id_ready),
    .rd_data (q_rd),
    .empty   (q_empty),
    .count   (q_cnt)
  );

  assign id_valid = ~q_empty;
  assign id_pc    = q_rd[EW-1 -: XLEN];
  assign id_ir    = q_rd[34:3];
  assign id_fault = ~q_empty & q_rd[2];
  assign id_cause = q_rd[1:0];

  a_trap_aligned: assert property (@(posedge clk) disable iff (reset)
    trap |-> (TRAP_ADDR[1:0] == 2'b00));
  a_tag_track: assert property (@(posedge clk) disable iff (reset)
    (tag_cnt == out_cnt_q) && (!imem_rsp_valid || !tag_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;
  import riscv::*;

  localparam logic [31:0] RST_A = riscv::INST_ADDR;
  localparam logic [31:0] TRP_A = riscv::TRAP_ADDR;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    logic        err;
    logic        stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_error = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        trap = 1'b0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_pc, id_ir;
  logic        id_fault;
  logic [1:0]  id_cause;

  fetch_unit #(
    .XLEN       (32),
    .DEPTH      (4),
    .RESET_ADDR (RST_A),
    .TRAP_ADDR  (TRP_A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_error (imem_rsp_error),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap           (trap),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_ir          (id_ir),
    .id_fault       (id_fault),
    .id_cause       (id_cause)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pops    = 0;
  int          hs_cnt  = 0;
  int unsigned cyc     = 0;
  int unsigned last_due = 0;

  mem_t memq[$];
  exp_t expq[$];

  logic [31:0] req_pc   = RST_A;
  logic        halted   = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  int unsigned lat = 1, rdy = 100, idr = 100;
  logic        rst_now = 1'b1, redir_now = 1'b0, trap_now = 1'b0;
  logic [31:0] redir_tgt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, update the reference model mid-cycle.
  task automatic step();
    logic [31:0] tgt;
    mem_t        m;
    @(posedge clk);
    #1;
    cyc++;
    reset          = rst_now;
    imem_req_ready = ($urandom_range(0, 99) < rdy);
    id_ready       = ($urandom_range(0, 99) < idr);
    redirect_valid = redir_now;
    redirect_addr  = redir_tgt;
    trap           = trap_now;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_error = 1'b0;
    if (!rst_now && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ KEY;
      imem_rsp_error = memq[0].err;
    end
    @(negedge clk);
    #1;
    if (reset) begin
      memq.delete();
      expq.delete();
      req_pc   = RST_A;
      halted   = 1'b0;
      last_due = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        hs_cnt++;
        chk("req_allowed", {31'b0, redirect_valid | trap | halted}, 32'd0);
        chk("req_addr", imem_req_addr, req_pc);
        m.addr  = req_pc;
        m.due   = (cyc + lat > last_due) ? cyc + lat : last_due;
        m.err   = (req_pc == err_addr);
        m.stale = 1'b0;
        last_due = m.due;
        memq.push_back(m);
        expq.push_back('{pc: req_pc, ir: req_pc ^ KEY, fault: m.err, cause: 2'd1});
        req_pc = req_pc + 32'd4;
      end
      if (imem_rsp_valid) begin
        m = memq.pop_front();
        if (!m.stale && m.err) halted = 1'b1;
      end
      if (redirect_valid || trap) begin
        foreach (memq[i]) memq[i].stale = 1'b1;
        expq.delete();
        tgt = trap ? TRP_A : redirect_addr;
        if (!trap && tgt[1:0] != 2'b00) begin
          expq.push_back('{pc: tgt, ir: 32'h0, fault: 1'b1, cause: 2'd0});
          halted = 1'b1;
        end else begin
          req_pc = tgt;
          halted = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst_now = 1'b1;
    step();
    step();
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    chk({tag, "_id_fault"}, {31'b0, id_fault}, 32'd0);
    rst_now = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic do_trap);
    redir_now = 1'b1;
    redir_tgt = tgt;
    trap_now  = do_trap;
    step();
    redir_now = 1'b0;
    trap_now  = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head entry is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && id_valid && id_ready && !redirect_valid && !trap) begin
        pops++;
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_entry: got pc %h, required no entry (cycle %0d)", id_pc, cyc);
        end else begin
          e = expq.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_ir", id_ir, e.ir);
          chk("id_fault", {31'b0, id_fault}, {31'b0, e.fault});
          if (e.fault) chk("id_cause", {30'b0, id_cause}, {30'b0, e.cause});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int  p0, h0;
    logic got;
    logic [31:0] tgt;

    do_reset("rst");

    // Single-cycle memory: first fetch, registered-output latency, steady stream.
    lat = 1; rdy = 100; idr = 100;
    step();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RST_A);
    step();
    chk("lat_not_yet", {31'b0, id_valid}, 32'd0);
    step();
    chk("lat_head_valid", {31'b0, id_valid}, 32'd1);
    chk("lat_head_pc", id_pc, RST_A);
    chk("lat_head_ir", id_ir, RST_A ^ KEY);
    p0 = pops;
    repeat (20) step();
    chk("stream_rate", pops - p0, 32'd20);

    // Decode stalled: credits cap issued fetches at DEPTH.
    do_reset("credit");
    idr = 0;
    h0 = hs_cnt;
    repeat (20) step();
    chk("credit_reqs", hs_cnt - h0, 32'd4);
    chk("credit_stall", {31'b0, imem_req_valid}, 32'd0);
    chk("credit_head", {31'b0, id_valid}, 32'd1);
    idr = 100;
    repeat (10) step();

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset("redir");
    lat = 3;
    step();
    step();
    redirect(32'h100, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (id_valid) got = 1'b1;
    end
    chk("redir_seen", {31'b0, got}, 32'd1);
    chk("redir_head_pc", id_pc, 32'h100);

    // Trap beats a simultaneous redirect.
    lat = 1;
    repeat (6) step();
    redirect(32'h200, 1'b1);
    step();
    chk("trap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("trap_req_addr", imem_req_addr, TRP_A);

    // Misaligned target: one fault entry, no fetch, halt until a new redirect.
    repeat (4) step();
    redirect(32'h102, 1'b0);
    h0 = hs_cnt;
    repeat (10) step();
    chk("mis_noreq", hs_cnt - h0, 32'd0);
    chk("mis_halt_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mis_drained", expq.size(), 32'd0);
    redirect(32'h40, 1'b0);
    h0 = hs_cnt;
    repeat (5) step();
    chk("mis_resume", {31'b0, hs_cnt > h0}, 32'd1);

    // Bus error on the response for 0x8.
    do_reset("berr");
    err_addr = 32'h8;
    h0 = hs_cnt;
    repeat (20) step();
    chk("berr_reqs", hs_cnt - h0, 32'd4);
    chk("berr_halt_valid", {31'b0, imem_req_valid}, 32'd0);
    err_addr = 32'hFFFF_FFFF;
    redirect(32'h40, 1'b0);
    h0 = hs_cnt;
    repeat (5) step();
    chk("berr_resume", {31'b0, hs_cnt > h0}, 32'd1);

    // Reset with requests in flight.
    lat = 3;
    repeat (3) step();
    do_reset("midrst");
    step();
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("midrst_req_addr", imem_req_addr, RST_A);

    // Randomised traffic with redirects, traps, misaligned targets and bus errors.
    rdy = 70; idr = 60;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 9))
          0:       begin tgt = TRP_A; redir_now = $urandom_range(0, 1); end
          1:       tgt = (($urandom & 32'h3FC) | 32'($urandom_range(1, 3)));
          default: tgt = 32'($urandom_range(0, 255)) << 2;
        endcase
        err_addr = ($urandom_range(0, 9) < 3) ? tgt + 32'($urandom_range(0, 12) * 4)
                                               : 32'hFFFF_FFFF;
        redirect(tgt, tgt == TRP_A);
      end else begin
        step();
      end
    end

    // Drain: no new fetches, decode always ready.
    rdy = 0; idr = 100;
    repeat (30) step();
    chk("drain_empty", expq.size(), 32'd0);
    chk("drain_idle", {31'b0, id_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
